// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizers for the raw PS/2 lines and a falling-edge detector on ps2_clk.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_q;
  logic [1:0] data_q;
  logic       clk_prev_q;

  // The clock chain resets high so a reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= 2'b11;
      clk_prev_q <= 1'b1;
      data_q     <= 2'b00;
    end else begin
      clk_q      <= {clk_q[0], ps2_clk};
      clk_prev_q <= clk_q[1];
      data_q     <= {data_q[0], ps2_data};
    end
  end

  assign data_sync = data_q[1];
  assign clk_fall  = clk_prev_q & ~clk_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver: frames bytes, checks parity/stop, folds E0/F0 prefixes into flags.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic data_s;
  logic fall;

  ps2_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_s),
    .clk_fall  (fall)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;
  logic [7:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            break_q, break_d;
  logic            ext_q, ext_d;
  logic            err_q, err_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmo_d      = tmo_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    break_d    = break_q;
    ext_d      = ext_q;
    err_d      = 1'b0;

    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (fall) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      // Keyboard stalled mid-frame: drop the partial byte and any pending prefix.
      state_d    = StIdle;
      tmo_d      = '0;
      err_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StParity: begin
          parity_d = data_s;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (ps2_parity_ok(shift_q, parity_q) && data_s) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d     = shift_q;
              valid_d    = 1'b1;
              break_d    = brk_pend_q;
              ext_d      = ext_pend_q;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end else begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      break_q    <= break_d;
      ext_q      <= ext_d;
      err_q      <= err_d;
    end
  end

  assign scan_code  = code_q;
  assign code_valid = valid_q;
  assign code_break = break_q;
  assign code_ext   = ext_q;
  assign frame_err  = err_q;

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the clk cycles without a PS/2 falling edge before an in-progress frame is aborted.
REQ-002 SHALL have port clk  input  1  system clock; one clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 SHALL have port scan_code  output  8  last decoded non-prefix scan code; feeds the scan-code-to-ASCII stage.
REQ-007 SHALL have port code_valid  output  1  one-cycle strobe marking a new scan_code.
REQ-008 SHALL have port code_break  output  1  key-release flag: scan_code was preceded by 8'hF0.
REQ-009 SHALL have port code_ext  output  1  extended-key flag: scan_code was preceded by 8'hE0.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two flops each, and SHALL detect a falling edge as previous synced clock 1 and current 0.
REQ-012 SHALL run a frame FSM with states IDLE, DATA, PARITY and STOP, advancing only on detected falling edges.
REQ-013 IDLE: on an edge with data=0 (start bit), SHALL go to DATA with bit count 0; on an edge with data=1, SHALL stay in IDLE with no error.
REQ-014 DATA: SHALL shift in 8 bits LSB first, and SHALL go to PARITY after the 8th bit.
REQ-015 PARITY: SHALL sample the parity bit and go to STOP.
REQ-016 STOP: SHALL sample the stop bit and return to IDLE.
REQ-017 A frame SHALL be good only if the data bits plus the parity bit hold an odd number of ones and the stop bit is 1; otherwise frame_err SHALL pulse and the byte SHALL be discarded.
REQ-018 The timeout counter SHALL clear on every falling edge and in IDLE.
REQ-019 Outside IDLE, when the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and frame_err SHALL pulse.
REQ-020 A good byte 8'hE0 SHALL set ext_pending, and a good byte 8'hF0 SHALL set brk_pending; neither SHALL produce code_valid.
REQ-021 Any other good byte SHALL, in the cycle after the stop-bit edge is detected, load scan_code, pulse code_valid, and copy brk_pending to code_break and ext_pending to code_ext; both pending flags SHALL then clear.
REQ-022 Sequence E0 F0 xx SHALL yield one code_valid with code_ext=1 and code_break=1.
REQ-023 Any frame_err SHALL clear both pending flags.
REQ-024 scan_code, code_break and code_ext SHALL hold their values until the next code_valid.
REQ-025 code_valid and frame_err SHALL never be asserted in the same cycle.
REQ-026 The timeout counter SHALL be just wide enough for TIMEOUT_CYCLES and SHALL not wrap.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE, and the counters, shift register, pending flags and synchronizer flops SHALL be 0, except the ps2_clk synchronizer flops, which SHALL reset to 1.
REQ-028 While rst_n=0, scan_code, code_valid, code_break, code_ext and frame_err SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without pulsing frame_err; after release, the first start bit SHALL begin a fresh frame.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state enum and the constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
REQ-031 One sub-module, ps2_sync, SHALL hold the two-flop synchronizers and the falling-edge detector.
REQ-032 Frame FSM, timeout and prefix logic SHALL live in ps2_scancode_rx.

Verification
REQ-033 Frame 0x1C with parity 0 and stop 1 -> one code_valid; scan_code=0x1C, code_break=0, code_ext=0.
REQ-034 Frames F0 then 1C -> exactly one code_valid; scan_code=0x1C, code_break=1, code_ext=0.
REQ-035 Frames E0, F0, 75 -> one code_valid; scan_code=0x75, code_ext=1, code_break=1; the next frame 0x72 gives both flags 0.
REQ-036 Frame 0x1C with parity 1 -> frame_err pulses once, no code_valid, and scan_code keeps its previous value.
REQ-037 Start bit plus 4 data bits then a stall of TIMEOUT_CYCLES clk -> frame_err pulses once; a following good frame 0x32 gives scan_code=0x32.
REQ-038 Frame F0 received, then rst_n pulsed low mid next frame -> all outputs 0 during reset; after release, frame 0x1C gives code_break=0.
